// File: rtl/ibuffer_pkg.sv
// Shared types and constants for the instruction buffer family.
//   INST_W      : instruction width
//   PC_W        : fetch PC width
//   PC_OUT_W    : PC width emitted toward decode
//   INSTR_BYTES : byte stride between adjacent fetch lanes
//   ibuf_entry_t: one stored instruction with its full PC
package ibuffer_pkg;

    localparam int unsigned INST_W      = 32;
    localparam int unsigned PC_W        = 64;
    localparam int unsigned PC_OUT_W    = 48;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } ibuf_entry_t;

endpackage

// File: rtl/ibuffer_compact.sv
// Prefix popcount over a lane valid mask.
//   mask     : per-lane valid bits
//   offset_c : number of set lanes below lane i (write slot relative to tail)
//   total_c  : number of set lanes in the whole mask
module ibuffer_compact #(
    parameter int unsigned FETCH_WIDTH = 4
) (
    input  logic [FETCH_WIDTH-1:0]         mask,
    output logic [$clog2(FETCH_WIDTH+1)-1:0] offset_c [FETCH_WIDTH],
    output logic [$clog2(FETCH_WIDTH+1)-1:0] total_c
);

    localparam int unsigned CNT_W = $clog2(FETCH_WIDTH + 1);

    logic [CNT_W-1:0] acc;

    // Running count: each lane's offset is the count before adding itself.
    always_comb begin
        acc = '0;
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            offset_c[i] = acc;
            acc         = acc + CNT_W'(mask[i]);
        end
        total_c = acc;
    end

endmodule

// File: rtl/ibuffer_multi.sv
// Multi-lane instruction buffer: compacts masked fetch blocks into a circular
// buffer and presents up to DEQ_WIDTH head instructions to decode.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   fetch_valid/ready   : fetch block handshake (ready = room for a full block)
//   fetch_instr/mask/pc : block payload, lane valid mask, PC of lane 0
//   flush               : discard all contents at the next edge
//   deq_valid/instr/pc  : head slots, combinational from registered state
//   deq_count           : number of head slots consumed this cycle
//   occupancy, empty    : current fill level
module ibuffer_multi #(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned DEQ_WIDTH   = 2,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned INST_W      = ibuffer_pkg::INST_W,
    parameter int unsigned PC_W        = ibuffer_pkg::PC_W,
    parameter int unsigned PC_OUT_W    = ibuffer_pkg::PC_OUT_W
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             fetch_valid,
    output logic                             fetch_ready,
    input  logic [FETCH_WIDTH*INST_W-1:0]    fetch_instr,
    input  logic [FETCH_WIDTH-1:0]           fetch_mask,
    input  logic [PC_W-1:0]                  fetch_pc,
    input  logic                             flush,
    output logic [DEQ_WIDTH-1:0]             deq_valid,
    output logic [DEQ_WIDTH*INST_W-1:0]      deq_instr,
    output logic [DEQ_WIDTH*PC_OUT_W-1:0]    deq_pc,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]   deq_count,
    output logic [$clog2(DEPTH+1)-1:0]       occupancy,
    output logic                             empty
);

    import ibuffer_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = $clog2(FETCH_WIDTH + 1);

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [OCC_W-1:0] occ_q;
    ibuf_entry_t      mem [DEPTH];

    logic [CNT_W-1:0] lane_off [FETCH_WIDTH];
    logic [CNT_W-1:0] lane_cnt;
    logic             room;
    logic             enq;
    logic [OCC_W-1:0] deq_req;
    logic [OCC_W-1:0] deq_n;
    ibuf_entry_t      slot;

    ibuffer_compact #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_compact (
        .mask     (fetch_mask),
        .offset_c (lane_off),
        .total_c  (lane_cnt)
    );

    // Room for a whole block, ignoring same-cycle dequeues.
    assign room        = (OCC_W'(DEPTH) - occ_q) >= OCC_W'(FETCH_WIDTH);
    assign fetch_ready = room && !reset;
    assign enq         = fetch_valid && room && !flush && !reset;

    // Over-requests are clamped to what is actually held.
    assign deq_req = OCC_W'(deq_count);
    assign deq_n   = (deq_req < occ_q) ? deq_req : occ_q;

    // Pointer and occupancy state; flush behaves like reset.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            occ_q    <= '0;
        end else begin
            head_ptr <= head_ptr + PTR_W'(deq_n);
            if (enq) begin
                tail_ptr <= tail_ptr + PTR_W'(lane_cnt);
                occ_q    <= occ_q + OCC_W'(lane_cnt) - deq_n;
            end else begin
                occ_q    <= occ_q - deq_n;
            end
        end
    end

    // Entry storage, not reset; set lanes land at consecutive slots past tail.
    always_ff @(posedge clock) begin
        if (enq) begin
            for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
                if (fetch_mask[i]) begin
                    mem[tail_ptr + PTR_W'(lane_off[i])] <= '{
                        inst: fetch_instr[i*INST_W +: INST_W],
                        pc:   fetch_pc + PC_W'(INSTR_BYTES * i)
                    };
                end
            end
        end
    end

    // Head view for decode.
    always_comb begin
        deq_valid = '0;
        deq_instr = '0;
        deq_pc    = '0;
        slot      = '0;
        for (int i = 0; i < int'(DEQ_WIDTH); i++) begin
            slot                               = mem[head_ptr + PTR_W'(i)];
            deq_valid[i]                       = !reset && (occ_q > OCC_W'(i));
            deq_instr[i*INST_W +: INST_W]      = slot.inst;
            deq_pc[i*PC_OUT_W +: PC_OUT_W]     = slot.pc[PC_OUT_W-1:0];
        end
    end

    assign occupancy = occ_q;
    assign empty     = (occ_q == '0);

endmodule

// File: tb/tb_ibuffer_multi.sv
module tb_ibuffer_multi;

    logic         clock;
    logic         reset;
    logic         fetch_valid;
    logic         fetch_ready;
    logic [127:0] fetch_instr;
    logic [3:0]   fetch_mask;
    logic [63:0]  fetch_pc;
    logic         flush;
    logic [1:0]   deq_valid;
    logic [63:0]  deq_instr;
    logic [95:0]  deq_pc;
    logic [1:0]   deq_count;
    logic [4:0]   occupancy;
    logic         empty;

    int checks;
    int failures;

    logic [31:0] q_inst[$];
    logic [63:0] q_pc[$];

    ibuffer_multi dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_instr (fetch_instr),
        .fetch_mask  (fetch_mask),
        .fetch_pc    (fetch_pc),
        .flush       (flush),
        .deq_valid   (deq_valid),
        .deq_instr   (deq_instr),
        .deq_pc      (deq_pc),
        .deq_count   (deq_count),
        .occupancy   (occupancy),
        .empty       (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [127:0] lanes(input logic [31:0] base);
        logic [127:0] r;
        for (int l = 0; l < 4; l++) r[l*32 +: 32] = base + 32'(l);
        return r;
    endfunction

    // One clock of stimulus; the queue model follows along, outputs sampled #1 after the edge.
    task automatic cycle(input logic fv, input logic [3:0] m, input logic [63:0] pc,
                         input logic [127:0] ins, input logic [1:0] dc, input logic fl);
        int  n;
        bit  rdy;
        fetch_valid = fv;
        fetch_mask  = m;
        fetch_pc    = pc;
        fetch_instr = ins;
        deq_count   = dc;
        flush       = fl;
        rdy = (16 - q_inst.size()) >= 4;
        if (fl) begin
            q_inst.delete();
            q_pc.delete();
        end else begin
            n = int'(dc);
            if (n > q_inst.size()) n = q_inst.size();
            repeat (n) begin
                void'(q_inst.pop_front());
                void'(q_pc.pop_front());
            end
            if (fv && rdy) begin
                for (int l = 0; l < 4; l++) begin
                    if (m[l]) begin
                        q_inst.push_back(ins[l*32 +: 32]);
                        q_pc.push_back(pc + 64'(4 * l));
                    end
                end
            end
        end
        @(posedge clock);
        #1;
        fetch_valid = 1'b0;
        fetch_mask  = '0;
        deq_count   = '0;
        flush       = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        fetch_valid = 1'b0;
        fetch_mask  = '0;
        fetch_pc    = '0;
        fetch_instr = '0;
        flush       = 1'b0;
        deq_count   = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (fetch_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_hi got=%b exp=0", fetch_ready); end
        checks++;
        if (deq_valid !== 2'b00) begin failures++; $display("FAIL rst_deq_valid_hi got=%b exp=00", deq_valid); end
        checks++;
        if (occupancy !== 5'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        reset = 1'b0;
        #1;
        checks++;
        if (fetch_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", fetch_ready); end
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL post_rst_empty got=%b exp=1", empty); end
        checks++;
        if (deq_valid !== 2'b00) begin failures++; $display("FAIL post_rst_deq_valid got=%b exp=00", deq_valid); end
    endtask

    task automatic test_full_block();
        cycle(1'b1, 4'b1111, 64'h8000_0000, lanes(32'h1111_0000), 2'd0, 1'b0);
        checks++;
        if (occupancy !== 5'd4) begin failures++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
        checks++;
        if (deq_valid !== 2'b11) begin failures++; $display("FAIL full_deq_valid got=%b exp=11", deq_valid); end
        checks++;
        if (deq_pc[47:0] !== 48'h0000_8000_0000) begin failures++; $display("FAIL full_pc0 got=%h exp=80000000", deq_pc[47:0]); end
        checks++;
        if (deq_pc[95:48] !== 48'h0000_8000_0004) begin failures++; $display("FAIL full_pc1 got=%h exp=80000004", deq_pc[95:48]); end
        checks++;
        if (deq_instr !== 64'h1111_0001_1111_0000) begin failures++; $display("FAIL full_instr got=%h exp=1111000111110000", deq_instr); end
        cycle(1'b0, 4'b0000, 64'h0, 128'h0, 2'd2, 1'b0);
        checks++;
        if (deq_instr[31:0] !== 32'h1111_0002) begin failures++; $display("FAIL full_after_deq got=%h exp=11110002", deq_instr[31:0]); end
        cycle(1'b0, 4'b0000, 64'h0, 128'h0, 2'd2, 1'b0);
        checks++;
        if (empty !== 1'b1 || occupancy !== 5'd0) begin failures++; $display("FAIL full_drain occ=%0d empty=%b exp=0/1", occupancy, empty); end
    endtask

    task automatic test_sparse_mask();
        logic [127:0] ins;
        ins = {32'hBBBB_0003, 32'hDEAD_0002, 32'hAAAA_0001, 32'hDEAD_0000};
        cycle(1'b1, 4'b1010, 64'h1000, ins, 2'd0, 1'b0);
        checks++;
        if (occupancy !== 5'd2) begin failures++; $display("FAIL sparse_occ got=%0d exp=2", occupancy); end
        checks++;
        if (deq_instr !== 64'hBBBB_0003_AAAA_0001) begin failures++; $display("FAIL sparse_instr got=%h exp=BBBB0003AAAA0001", deq_instr); end
        checks++;
        if (deq_pc !== {48'h100C, 48'h1004}) begin failures++; $display("FAIL sparse_pc got=%h exp=100c/1004", deq_pc); end
        cycle(1'b0, 4'b0000, 64'h0, 128'h0, 2'd2, 1'b0);
        checks++;
        if (occupancy !== 5'd0) begin failures++; $display("FAIL sparse_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_backpressure();
        cycle(1'b1, 4'b1111, 64'h3000, lanes(32'h3000_0000), 2'd0, 1'b0);
        cycle(1'b1, 4'b1111, 64'h3010, lanes(32'h3100_0000), 2'd0, 1'b0);
        cycle(1'b1, 4'b1111, 64'h3020, lanes(32'h3200_0000), 2'd0, 1'b0);
        cycle(1'b1, 4'b0001, 64'h3030, lanes(32'h3300_0000), 2'd0, 1'b0);
        checks++;
        if (occupancy !== 5'd13) begin failures++; $display("FAIL bp_occ13 got=%0d exp=13", occupancy); end
        checks++;
        if (fetch_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", fetch_ready); end
        cycle(1'b1, 4'b1111, 64'h4000, lanes(32'h4000_0000), 2'd2, 1'b0);
        checks++;
        if (occupancy !== 5'd11) begin failures++; $display("FAIL bp_rejected got=%0d exp=11", occupancy); end
        checks++;
        if (fetch_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", fetch_ready); end
        cycle(1'b1, 4'b1111, 64'h4000, lanes(32'h4000_0000), 2'd0, 1'b0);
        checks++;
        if (occupancy !== 5'd15) begin failures++; $display("FAIL bp_occ15 got=%0d exp=15", occupancy); end
        checks++;
        if (deq_instr !== 64'h3000_0003_3000_0002) begin failures++; $display("FAIL bp_head got=%h exp=3000000330000002", deq_instr); end
        cycle(1'b0, 4'b0000, 64'h0, 128'h0, 2'd0, 1'b1);
    endtask

    task automatic test_random();
        int          accepted;
        int          cyc;
        logic [1:0]  ev;
        logic [3:0]  m;
        logic [1:0]  dc;
        logic [63:0] pc;
        logic [127:0] ins;
        bit          rdy;
        accepted = 0;
        cyc      = 0;
        while (accepted < 200 && cyc < 4000) begin
            ev[0] = q_inst.size() > 0;
            ev[1] = q_inst.size() > 1;
            checks++;
            if (int'(occupancy) != q_inst.size() || occupancy > 5'd16) begin
                failures++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", cyc, occupancy, q_inst.size());
            end
            checks++;
            if (deq_valid !== ev) begin failures++; $display("FAIL rnd_deq_valid cyc=%0d got=%b exp=%b", cyc, deq_valid, ev); end
            checks++;
            if (fetch_ready !== ((16 - q_inst.size()) >= 4)) begin
                failures++; $display("FAIL rnd_ready cyc=%0d got=%b size=%0d", cyc, fetch_ready, q_inst.size());
            end
            for (int i = 0; i < 2; i++) begin
                if (i < q_inst.size()) begin
                    checks++;
                    if (deq_instr[i*32 +: 32] !== q_inst[i] || deq_pc[i*48 +: 48] !== q_pc[i][47:0]) begin
                        failures++;
                        $display("FAIL rnd_slot%0d cyc=%0d got=%h/%h exp=%h/%h", i, cyc,
                                 deq_instr[i*32 +: 32], deq_pc[i*48 +: 48], q_inst[i], q_pc[i][47:0]);
                    end
                end
            end
            rdy = (16 - q_inst.size()) >= 4;
            m   = 4'($urandom_range(0, 15));
            dc  = 2'($urandom_range(0, 2));
            pc  = {$urandom(), $urandom()};
            ins = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle(1'b1, m, pc, ins, dc, 1'b0);
            if (rdy) accepted++;
            cyc++;
        end
        checks++;
        if (accepted != 200) begin failures++; $display("FAIL rnd_timeout accepted=%0d exp=200", accepted); end
        cycle(1'b0, 4'b0000, 64'h0, 128'h0, 2'd0, 1'b1);
    endtask

    task automatic test_flush();
        cycle(1'b1, 4'b1111, 64'h5000, lanes(32'h5000_0000), 2'd0, 1'b0);
        cycle(1'b1, 4'b0111, 64'h5010, lanes(32'h5100_0000), 2'd0, 1'b0);
        checks++;
        if (occupancy !== 5'd7) begin failures++; $display("FAIL fl_occ7 got=%0d exp=7", occupancy); end
        cycle(1'b1, 4'b1111, 64'h9000, lanes(32'hDDDD_0000), 2'd2, 1'b1);
        checks++;
        if (occupancy !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL fl_occ got=%0d/%b exp=0/1", occupancy, empty); end
        checks++;
        if (deq_valid !== 2'b00) begin failures++; $display("FAIL fl_deq_valid got=%b exp=00", deq_valid); end
        checks++;
        if (fetch_ready !== 1'b1) begin failures++; $display("FAIL fl_ready got=%b exp=1", fetch_ready); end
        cycle(1'b1, 4'b0001, 64'h2000, lanes(32'h6000_0000), 2'd0, 1'b0);
        checks++;
        if (deq_valid !== 2'b01 || deq_instr[31:0] !== 32'h6000_0000 || deq_pc[47:0] !== 48'h2000) begin
            failures++; $display("FAIL fl_after got=%b/%h/%h exp=01/60000000/2000", deq_valid, deq_instr[31:0], deq_pc[47:0]);
        end
    endtask

    task automatic test_underflow_and_reset();
        cycle(1'b0, 4'b0000, 64'h0, 128'h0, 2'd2, 1'b0);
        checks++;
        if (occupancy !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL uf_occ got=%0d/%b exp=0/1", occupancy, empty); end
        checks++;
        if (deq_valid !== 2'b00) begin failures++; $display("FAIL uf_deq_valid got=%b exp=00", deq_valid); end
        cycle(1'b1, 4'b1111, 64'h7000, lanes(32'h7000_0000), 2'd0, 1'b0);
        cycle(1'b1, 4'b1111, 64'h7010, lanes(32'h7100_0000), 2'd0, 1'b0);
        cycle(1'b1, 4'b0001, 64'h7020, lanes(32'h7200_0000), 2'd0, 1'b0);
        checks++;
        if (occupancy !== 5'd9) begin failures++; $display("FAIL mr_occ9 got=%0d exp=9", occupancy); end
        reset       = 1'b1;
        fetch_valid = 1'b1;
        fetch_mask  = 4'b1111;
        deq_count   = 2'd1;
        @(posedge clock);
        #1;
        checks++;
        if (occupancy !== 5'd0) begin failures++; $display("FAIL mr_occ got=%0d exp=0", occupancy); end
        checks++;
        if (deq_valid !== 2'b00 || fetch_ready !== 1'b0) begin
            failures++; $display("FAIL mr_outputs got=%b/%b exp=00/0", deq_valid, fetch_ready);
        end
        reset       = 1'b0;
        fetch_valid = 1'b0;
        fetch_mask  = '0;
        deq_count   = '0;
        q_inst.delete();
        q_pc.delete();
        #1;
        checks++;
        if (fetch_ready !== 1'b1 || empty !== 1'b1) begin failures++; $display("FAIL mr_release got=%b/%b exp=1/1", fetch_ready, empty); end
        cycle(1'b1, 4'b0011, 64'hA000, lanes(32'h8000_0000), 2'd0, 1'b0);
        checks++;
        if (occupancy !== 5'd2 || deq_pc[95:48] !== 48'hA004 || deq_instr[63:32] !== 32'h8000_0001) begin
            failures++; $display("FAIL mr_refill got=%0d/%h/%h exp=2/a004/80000001", occupancy, deq_pc[95:48], deq_instr[63:32]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_full_block();
        test_sparse_mask();
        test_backpressure();
        test_random();
        test_flush();
        test_underflow_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibuffer_multi.md
Name: ibuffer_multi

Overview:
Parametrised successor to the front-end instruction buffer. It accepts one aligned fetch block per cycle, up to FETCH_WIDTH instructions with a per-lane valid mask. Valid lanes are compacted in lane order into a circular buffer of DEPTH entries. The block presents up to DEQ_WIDTH head instructions per cycle to decode, which consumes 0..DEQ_WIDTH of them in order. It replaces one-instruction-per-cycle draining with same-cycle bulk enqueue and multi-issue dequeue, explicit ready/valid backpressure, and single-cycle flush.

Parameters:
FETCH_WIDTH, 4, instruction lanes per fetch block (power of 2)
DEQ_WIDTH, 2, maximum instructions presented/consumed per cycle (1..FETCH_WIDTH)
DEPTH, 16, buffer entries (power of 2, >= 2*FETCH_WIDTH)
INST_W, 32, instruction width
PC_W, 64, input PC width
PC_OUT_W, 48, emitted PC width (low bits of PC)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high reset
fetch_valid  in  1  fetch block present
fetch_ready  out  1  buffer can accept a full block this cycle
fetch_instr  in  FETCH_WIDTH*INST_W  lane i at bits [i*INST_W +: INST_W]
fetch_mask  in  FETCH_WIDTH  per-lane valid
fetch_pc  in  PC_W  PC of lane 0
flush  in  1  discard all contents (redirect)
deq_valid  out  DEQ_WIDTH  slot i holds a valid instruction
deq_instr  out  DEQ_WIDTH*INST_W  head+i instruction
deq_pc  out  DEQ_WIDTH*PC_OUT_W  head+i PC[PC_OUT_W-1:0]
deq_count  in  $clog2(DEQ_WIDTH+1)  number of head slots consumed this cycle
occupancy  out  $clog2(DEPTH+1)  current entry count
empty  out  1  occupancy == 0

Behaviour:
- Reset (synchronous, active-high, sampled at clock edge) sets head_ptr=0, tail_ptr=0, occupancy=0. Entry storage is not reset.
- While reset is high, fetch_ready=0 and deq_valid=0. In the first cycle after reset: fetch_ready=1, empty=1, deq_valid=0.
- fetch_ready = (DEPTH - occupancy) >= FETCH_WIDTH, computed combinationally from the registered occupancy.
  - It does not count same-cycle dequeues; this is deliberately conservative.
  - It does not depend on fetch_valid.
- Enqueue fires when fetch_valid && fetch_ready && !flush.
  - Enqueue is all-or-nothing: the whole block is taken or none of it.
  - Set lanes are written in ascending lane order to tail_ptr, tail_ptr+1, ... (mod DEPTH).
  - PC of lane i = fetch_pc + 4*i, full PC_W add; truncation happens only at output.
  - tail_ptr advances by popcount(fetch_mask).
  - A firing enqueue with fetch_mask==0 is a legal no-op.
- Dequeue view is combinational from registers:
  - deq_valid[i] = occupancy > i.
  - deq_instr/deq_pc slot i show entry (head_ptr+i) mod DEPTH.
  - Invalid slots drive don't-care data.
- Dequeue takes effective count n = min(deq_count, occupancy); over-request is clamped, never underflows. head_ptr advances by n.
- Simultaneous enqueue and dequeue: next occupancy = occupancy + popcount(mask) - n. Both take effect in the same cycle.
- Latency: an instruction enqueued at edge k is visible on deq_* in the cycle after edge k. There is no bypass from fetch_* to deq_*.
- flush has priority over everything.
  - At the next edge: head_ptr=tail_ptr=0 and occupancy=0.
  - Any same-cycle enqueue and dequeue are discarded.
  - deq_* outputs in the flush cycle still reflect pre-flush state; the consumer must ignore them.
- Pointers are $clog2(DEPTH) bits and wrap naturally mod DEPTH. occupancy is $clog2(DEPTH+1) bits and reaches DEPTH exactly when full.
- Fetch-request pulse generation is not part of this block: fetch_ready is the request.

Decomposition:
- Shared package ibuffer_pkg:
  - INST_W, PC_OUT_W, the instruction-size constant 4.
  - Packed typedef ibuf_entry_t {inst[INST_W], pc[PC_W]}.
- Sub-module ibuffer_compact:
  - Combinational prefix-popcount over fetch_mask.
  - Produces per-lane write offset and total count.
  - Also reused by the future decode-side compactor.
- Pointer/occupancy registers and storage stay in ibuffer_multi.

Test Plan:
1. Reset held 2 cycles, then fetch_mask=4'b1111, fetch_pc=0x8000_0000 -> next cycle occupancy=4; deq_pc = 0x8000_0000, 0x8000_0004; deq_valid=2'b11.
2. From empty, fetch_mask=4'b1010, fetch_pc=0x1000, instr lanes 1/3 = 0xAAAA_0001/0xBBBB_0003 -> occupancy=2; slot0 = (0xAAAA_0001, 0x1004); slot1 = (0xBBBB_0003, 0x100C).
3. Fill to occupancy=13 -> fetch_ready=0. Assert fetch_valid with deq_count=2 -> block not accepted, occupancy=11. Next cycle fetch_ready=1 and the block is accepted -> occupancy 15 (deq_count=0).
4. Random masks with random deq_count 0..2, 200 blocks, checked against a scoreboard -> dequeued (inst,pc) order exactly matches enqueued lane order across many pointer wraps; occupancy never exceeds 16.
5. occupancy=7, flush together with fetch_valid and deq_count=2 -> next cycle occupancy=0, empty=1, deq_valid=0, fetch_ready=1; the discarded block never appears.
6. occupancy=1, deq_count=2 -> occupancy=0, no underflow. Then reset asserted mid-stream at occupancy=9 -> occupancy=0 and deq_valid=0 after the edge.
